// File: rtl/demux_1x16_reg_if.sv
// Bus bundle for the registered 1-to-16 demultiplexer.
// Master drives din/sel/clear; slave returns the lane bank and status.
interface demux_1x16_reg_if #(
    parameter int DW = 1
);
    logic [DW-1:0]    din;
    logic             din_valid;
    logic [3:0]       sel;
    logic             clear;
    logic [16*DW-1:0] q;
    logic             q_valid;
    logic [3:0]       q_idx;
    logic [15:0]      written;
    logic             frame_done;

    modport master (
        output din, din_valid, sel, clear,
        input  q, q_valid, q_idx, written, frame_done
    );

    modport slave (
        input  din, din_valid, sel, clear,
        output q, q_valid, q_idx, written, frame_done
    );
endinterface

// File: rtl/demux_1x16_reg.sv
// Registered 1-to-16 demux: group decode stage, then lane write stage.
// Optional DEMUX_1X16_AUTO_SEL_EN replaces sel with an internal write pointer.
module demux_1x16_reg #(
    parameter int            DW     = 1,
    parameter logic [DW-1:0] Q_INIT = '0
) (
    input  logic clk,
    input  logic rst_n,
    demux_1x16_reg_if.slave bus
);

    logic [3:0]       lane_sel;
    logic [3:0]       grp_d;

    logic             s1_vld_q;
    logic [DW-1:0]    s1_din_q;
    logic [3:0]       s1_grp_q;
    logic [1:0]       s1_lo_q;

    logic [1:0]       grp_idx;
    logic [3:0]       wr_idx;
    logic [15:0]      base_mask;
    logic [15:0]      mask_d;
    logic             wr_new;
    logic             done_d;
    logic [15:0]      written_d;

    logic [16*DW-1:0] q_q;
    logic             q_valid_q;
    logic [3:0]       q_idx_q;
    logic [15:0]      written_q;
    logic             frame_done_q;

`ifdef DEMUX_1X16_AUTO_SEL_EN
    logic [3:0] ptr_q;
    logic [3:0] ptr_d;

    assign ptr_d    = ptr_q + 4'd1;
    assign lane_sel = ptr_q;

    // Write pointer advances on every accepted word, wrapping 15 -> 0
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            ptr_q <= '0;
        end else if (bus.din_valid) begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign lane_sel = bus.sel;
`endif

    // Coarse decode of the lane group into a one-hot enable
    always_comb begin
        grp_d = '0;
        grp_d[lane_sel[3:2]] = 1'b1;
    end

    // Stage 1: capture word, valid and decoded group
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_din_q <= '0;
            s1_grp_q <= '0;
            s1_lo_q  <= '0;
        end else if (bus.clear) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= bus.din_valid;
            s1_din_q <= bus.din;
            s1_grp_q <= grp_d;
            s1_lo_q  <= lane_sel[1:0];
        end
    end

    // Re-encode the one-hot group into the upper lane index bits
    always_comb begin
        grp_idx = 2'd0;
        unique case (1'b1)
            s1_grp_q[0]: grp_idx = 2'd0;
            s1_grp_q[1]: grp_idx = 2'd1;
            s1_grp_q[2]: grp_idx = 2'd2;
            s1_grp_q[3]: grp_idx = 2'd3;
            default:     grp_idx = 2'd0;
        endcase
    end

    // Mask update: a completed frame restarts from an empty mask
    always_comb begin
        wr_idx    = {grp_idx, s1_lo_q};
        base_mask = frame_done_q ? 16'h0000 : written_q;
        mask_d    = base_mask | (16'h0001 << wr_idx);
        wr_new    = ~base_mask[wr_idx];
        done_d    = s1_vld_q && wr_new && (&mask_d);
        written_d = s1_vld_q ? mask_d : base_mask;
    end

    // Stage 2: lane write, status pulses and written mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q          <= {16{Q_INIT}};
            q_valid_q    <= 1'b0;
            q_idx_q      <= '0;
            written_q    <= '0;
            frame_done_q <= 1'b0;
        end else if (bus.clear) begin
            q_q          <= {16{Q_INIT}};
            q_valid_q    <= 1'b0;
            written_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            q_valid_q    <= s1_vld_q;
            frame_done_q <= done_d;
            written_q    <= written_d;
            if (s1_vld_q) begin
                q_q[wr_idx*DW +: DW] <= s1_din_q;
                q_idx_q              <= wr_idx;
            end
        end
    end

    assign bus.q          = q_q;
    assign bus.q_valid    = q_valid_q;
    assign bus.q_idx      = q_idx_q;
    assign bus.written    = written_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_1x16_reg.sv
// Directed testbench for demux_1x16_reg (DW=1, Q_INIT=0).
// Define DEMUX_1X16_AUTO_SEL_EN to exercise the pointer build instead.
module tb_demux_1x16_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    demux_1x16_reg_if #(.DW(1)) bus ();

    demux_1x16_reg #(
        .DW     (1),
        .Q_INIT (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic d);
        bus.din_valid = v;
        bus.sel       = s;
        bus.din       = d;
    endtask

    task automatic do_clear();
        drive(1'b0, 4'd0, 1'b0);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.clear = 1'b0;
        drive(1'b1, 4'd9, 1'b1);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.q_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_qvalid got=%b exp=0", bus.q_valid);
        end
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0);
        step();
        checks++;
        if (bus.q !== 16'h0000 || bus.written !== 16'h0000 ||
            bus.q_valid !== 1'b0 || bus.frame_done !== 1'b0 ||
            bus.q_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_state q=%h wr=%h qv=%b fd=%b idx=%0d exp 0",
                     bus.q, bus.written, bus.q_valid, bus.frame_done,
                     bus.q_idx);
        end
    endtask

    task automatic test_latency();
        drive(1'b1, 4'd9, 1'b1);
        step();
        drive(1'b0, 4'd0, 1'b0);
        checks++;
        if (bus.q !== 16'h0000 || bus.q_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_n1 q=%h qv=%b exp q=0000 qv=0",
                     bus.q, bus.q_valid);
        end
        step();
        checks++;
        if (bus.q !== 16'h0200 || bus.q_valid !== 1'b1 ||
            bus.q_idx !== 4'd9 || bus.written !== 16'h0200) begin
            failures++;
            $display("FAIL latency_n2 q=%h qv=%b idx=%0d wr=%h exp 0200/1/9/0200",
                     bus.q, bus.q_valid, bus.q_idx, bus.written);
        end
        step();
        checks++;
        if (bus.q_valid !== 1'b0 || bus.q !== 16'h0200) begin
            failures++;
            $display("FAIL latency_n3 q=%h qv=%b exp 0200/0",
                     bus.q, bus.q_valid);
        end
    endtask

`ifndef DEMUX_1X16_AUTO_SEL_EN
    task automatic test_full_frame();
        int pulses;
        pulses = 0;
        do_clear();
        for (int k = 0; k < 18; k++) begin
            if (k < 16) drive(1'b1, 4'(k), k[0]);
            else        drive(1'b0, 4'd0, 1'b0);
            step();
            if (bus.frame_done === 1'b1) pulses++;
            if (k == 16) begin
                checks++;
                if (bus.q !== 16'hAAAA || bus.frame_done !== 1'b1 ||
                    bus.written !== 16'hFFFF || bus.q_idx !== 4'd15) begin
                    failures++;
                    $display("FAIL frame_last q=%h fd=%b wr=%h idx=%0d exp AAAA/1/FFFF/15",
                             bus.q, bus.frame_done, bus.written, bus.q_idx);
                end
            end
            if (k == 17) begin
                checks++;
                if (bus.written !== 16'h0000 || bus.frame_done !== 1'b0 ||
                    bus.q !== 16'hAAAA) begin
                    failures++;
                    $display("FAIL frame_after wr=%h fd=%b q=%h exp 0000/0/AAAA",
                             bus.written, bus.frame_done, bus.q);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL frame_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_rewrite();
        int pulses;
        int lane;
        pulses = 0;
        do_clear();
        for (int k = 0; k < 19; k++) begin
            if (k < 2)       lane = 3;
            else if (k < 5)  lane = k - 2;
            else             lane = k - 1;
            if (k < 17) drive(1'b1, 4'(lane), (k == 1) ? 1'b0 : 1'b1);
            else        drive(1'b0, 4'd0, 1'b0);
            step();
            if (bus.frame_done === 1'b1) pulses++;
            if (k == 2) begin
                checks++;
                if (bus.q !== 16'h0000 || bus.written !== 16'h0008 ||
                    bus.frame_done !== 1'b0 || bus.q_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rewrite_dup q=%h wr=%h fd=%b qv=%b exp 0000/0008/0/1",
                             bus.q, bus.written, bus.frame_done, bus.q_valid);
                end
            end
            if (k == 17) begin
                checks++;
                if (bus.q !== 16'hFFF7 || bus.frame_done !== 1'b1) begin
                    failures++;
                    $display("FAIL rewrite_done q=%h fd=%b exp FFF7/1",
                             bus.q, bus.frame_done);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL rewrite_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_clear_mid();
        drive(1'b1, 4'd5, 1'b1);
        step();
        drive(1'b1, 4'd6, 1'b1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
        checks++;
        if (bus.q !== 16'h0000 || bus.written !== 16'h0000 ||
            bus.q_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL clear_n2 q=%h wr=%h qv=%b fd=%b exp 0000/0000/0/0",
                     bus.q, bus.written, bus.q_valid, bus.frame_done);
        end
        step();
        checks++;
        if (bus.q !== 16'h0000 || bus.q_valid !== 1'b0 ||
            bus.written !== 16'h0000) begin
            failures++;
            $display("FAIL clear_n3 q=%h qv=%b wr=%h exp 0000/0/0000",
                     bus.q, bus.q_valid, bus.written);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'd2, 1'b1);
        step();
        drive(1'b1, 4'd2, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b0);
        checks++;
        if (bus.q !== 16'h0004 || bus.q_valid !== 1'b1 || bus.q_idx !== 4'd2) begin
            failures++;
            $display("FAIL b2b_first q=%h qv=%b idx=%0d exp 0004/1/2",
                     bus.q, bus.q_valid, bus.q_idx);
        end
        step();
        checks++;
        if (bus.q !== 16'h0000 || bus.q_valid !== 1'b1 ||
            bus.written !== 16'h0004) begin
            failures++;
            $display("FAIL b2b_second q=%h qv=%b wr=%h exp 0000/1/0004",
                     bus.q, bus.q_valid, bus.written);
        end
        step();
        checks++;
        if (bus.q_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle qv=%b exp 0", bus.q_valid);
        end
    endtask

    task automatic test_clear_vs_complete();
        int pulses;
        pulses = 0;
        do_clear();
        for (int k = 0; k < 18; k++) begin
            if (k < 16) drive(1'b1, 4'(k), 1'b1);
            else        drive(1'b0, 4'd0, 1'b0);
            bus.clear = (k == 16);
            step();
            bus.clear = 1'b0;
            if (bus.frame_done === 1'b1) pulses++;
            if (k == 15) begin
                checks++;
                if (bus.written !== 16'h7FFF || bus.q !== 16'h7FFF) begin
                    failures++;
                    $display("FAIL cvc_pre wr=%h q=%h exp 7FFF/7FFF",
                             bus.written, bus.q);
                end
            end
            if (k == 16) begin
                checks++;
                if (bus.written !== 16'h0000 || bus.q !== 16'h0000 ||
                    bus.q_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL cvc_clear wr=%h q=%h qv=%b exp 0000/0000/0",
                             bus.written, bus.q, bus.q_valid);
                end
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL cvc_pulses got=%0d exp=0", pulses);
        end
    endtask
`else
    task automatic test_auto_sel();
        int pulses;
        pulses = 0;
        do_clear();
        for (int k = 0; k < 22; k++) begin
            if (k < 20) drive(1'b1, 4'($urandom_range(0, 15)), 1'b1);
            else        drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            step();
            if (bus.frame_done === 1'b1) pulses++;
            if (k == 16) begin
                checks++;
                if (bus.frame_done !== 1'b1 || bus.written !== 16'hFFFF ||
                    bus.q !== 16'hFFFF || bus.q_idx !== 4'd15) begin
                    failures++;
                    $display("FAIL auto_16th fd=%b wr=%h q=%h idx=%0d exp 1/FFFF/FFFF/15",
                             bus.frame_done, bus.written, bus.q, bus.q_idx);
                end
            end
            if (k == 17) begin
                checks++;
                if (bus.written !== 16'h0001 || bus.q_idx !== 4'd0) begin
                    failures++;
                    $display("FAIL auto_wrap wr=%h idx=%0d exp 0001/0",
                             bus.written, bus.q_idx);
                end
            end
            if (k == 21) begin
                checks++;
                if (bus.written !== 16'h000F || bus.q_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL auto_tail wr=%h qv=%b exp 000F/0",
                             bus.written, bus.q_valid);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL auto_pulses got=%0d exp=1", pulses);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.clear = 1'b0;
        drive(1'b0, 4'd0, 1'b0);
        test_reset();
        test_latency();
`ifndef DEMUX_1X16_AUTO_SEL_EN
        test_full_frame();
        test_rewrite();
        test_clear_mid();
        test_back_to_back();
        test_clear_vs_complete();
`else
        test_auto_sel();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
